// File: rtl/filter_video_gen_if.sv
// Video bus carried from the test-pattern source to the filter input:
// vs/hs/de timing strobes plus Y/U/V components, all active-high.
interface filter_video_gen_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  vs;
   logic                  hs;
   logic                  de;
   logic [DATA_WIDTH-1:0] y;
   logic [DATA_WIDTH-1:0] u;
   logic [DATA_WIDTH-1:0] v;

   modport master (output vs, hs, de, y, u, v);
   modport slave  (input  vs, hs, de, y, u, v);
endinterface

// File: rtl/filter_video_gen.sv
// Test-pattern video source: h/v counters, IDLE/RUN/STOP control FSM and a Y/U/V pattern generator.
// Define FILTER_VGEN_FRAME_CNT_EN to add the o_frame_cnt completed-frame counter port.
module filter_video_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int H_ACTIVE   = 1280,
   parameter int H_FP       = 110,
   parameter int H_SYNC     = 40,
   parameter int H_BP       = 220,
   parameter int V_ACTIVE   = 720,
   parameter int V_FP       = 5,
   parameter int V_SYNC     = 5,
   parameter int V_BP       = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [1:0]           i_pattern,
   output logic                 o_busy,
   output logic [1:0]           o_state,
`ifdef FILTER_VGEN_FRAME_CNT_EN
   output logic [15:0]          o_frame_cnt,
`endif
   filter_video_gen_if.master   vid
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // Counters are at least 8 bits wide so the ramps can always take the low byte.
   localparam int H_W   = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
   localparam int V_W   = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BP_W  = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

   localparam logic [H_W-1:0]  H_ACT_L  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0]  HS_BEG_L = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0]  HS_END_L = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [H_W-1:0]  H_LAST_L = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0]  V_ACT_L  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0]  VS_BEG_L = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0]  VS_END_L = V_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [V_W-1:0]  V_LAST_L = V_W'(V_TOTAL - 1);
   localparam logic [BP_W-1:0] BP_LAST  = BP_W'(BAR_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [H_W-1:0]  h_cnt;
   logic [V_W-1:0]  v_cnt;
   logic [BP_W-1:0] bar_pix;
   logic [2:0]      bar_idx;
   logic [1:0]      pat_q;
   logic [1:0]      pat_sel;
   logic            h_last, v_last, frame_last, frame_start;
   logic            counting, latch_pat;
   logic            de_c, hs_c, vs_c;
   logic [DATA_WIDTH-1:0] y_c, u_c, v_c;

   assign h_last      = (h_cnt == H_LAST_L);
   assign v_last      = (v_cnt == V_LAST_L);
   assign frame_last  = h_last && v_last;
   assign frame_start = (h_cnt == '0) && (v_cnt == '0);
   assign o_state     = state_q;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state. A returning run request in STOP wins over the frame end,
   // so re-raising i_en before the last pixel gives back-to-back frames.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_en) state_d = ST_RUN;
         ST_RUN:  if (!i_en) state_d = ST_STOP;
         ST_STOP: begin
            if (i_en)            state_d = ST_RUN;
            else if (frame_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      counting  = 1'b0;
      latch_pat = 1'b0;
      case (state_q)
         ST_IDLE: latch_pat = i_en;
         ST_RUN, ST_STOP: begin
            counting  = 1'b1;
            latch_pat = frame_start;
         end
         default: ;
      endcase
   end

   // Counters wrap naturally at the frame end, which also lands STOP->IDLE at (0,0).
   always_ff @(posedge clk) begin
      if (rst || !counting) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         bar_pix <= '0;
         bar_idx <= '0;
      end else begin
         if (h_last) begin
            h_cnt   <= '0;
            bar_pix <= '0;
            bar_idx <= '0;
            v_cnt   <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
            if (h_cnt < H_ACT_L) begin
               if (bar_pix == BP_LAST) begin
                  bar_pix <= '0;
                  bar_idx <= bar_idx + 1'b1;
               end else begin
                  bar_pix <= bar_pix + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            pat_q <= 2'd0;
      else if (latch_pat) pat_q <= i_pattern;
   end

   // The first pixel of a frame already shows the pattern being latched there.
   assign pat_sel = frame_start ? i_pattern : pat_q;

   assign de_c = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
   assign hs_c = (h_cnt >= HS_BEG_L) && (h_cnt < HS_END_L);
   assign vs_c = (v_cnt >= VS_BEG_L) && (v_cnt < VS_END_L);

   always_comb begin
      y_c = '0;
      u_c = '0;
      v_c = '0;
      if (de_c) begin
         u_c = DATA_WIDTH'(128);
         v_c = DATA_WIDTH'(128);
         case (pat_sel)
            2'd0: y_c = DATA_WIDTH'(h_cnt[7:0]);
            2'd1: y_c = DATA_WIDTH'(v_cnt[7:0]);
            2'd2: y_c = (h_cnt[3] ^ v_cnt[3]) ? DATA_WIDTH'(235) : DATA_WIDTH'(16);
            default: begin
               case (bar_idx)
                  3'd0: begin y_c = DATA_WIDTH'(235); u_c = DATA_WIDTH'(128); v_c = DATA_WIDTH'(128); end
                  3'd1: begin y_c = DATA_WIDTH'(210); u_c = DATA_WIDTH'(16);  v_c = DATA_WIDTH'(146); end
                  3'd2: begin y_c = DATA_WIDTH'(170); u_c = DATA_WIDTH'(166); v_c = DATA_WIDTH'(16);  end
                  3'd3: begin y_c = DATA_WIDTH'(145); u_c = DATA_WIDTH'(54);  v_c = DATA_WIDTH'(34);  end
                  3'd4: begin y_c = DATA_WIDTH'(106); u_c = DATA_WIDTH'(202); v_c = DATA_WIDTH'(222); end
                  3'd5: begin y_c = DATA_WIDTH'(81);  u_c = DATA_WIDTH'(90);  v_c = DATA_WIDTH'(240); end
                  3'd6: begin y_c = DATA_WIDTH'(41);  u_c = DATA_WIDTH'(240); v_c = DATA_WIDTH'(110); end
                  default: begin y_c = DATA_WIDTH'(16); u_c = DATA_WIDTH'(128); v_c = DATA_WIDTH'(128); end
               endcase
            end
         endcase
      end
   end

   // Output register: everything is forced low while idle or in reset.
   always_ff @(posedge clk) begin
      if (rst || !counting) begin
         o_busy <= 1'b0;
         vid.vs <= 1'b0;
         vid.hs <= 1'b0;
         vid.de <= 1'b0;
         vid.y  <= '0;
         vid.u  <= '0;
         vid.v  <= '0;
      end else begin
         o_busy <= 1'b1;
         vid.vs <= vs_c;
         vid.hs <= hs_c;
         vid.de <= de_c;
         vid.y  <= y_c;
         vid.u  <= u_c;
         vid.v  <= v_c;
      end
   end

`ifdef FILTER_VGEN_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)                          o_frame_cnt <= 16'd0;
      else if (counting && frame_last)  o_frame_cnt <= o_frame_cnt + 16'd1;
   end
`endif
endmodule
